// File: rtl/atm_session_driver.sv
// -----------------------------------------------------------------------------
// atm_session_driver
//   Initiator side of the ATM customer interface. Turns one host request
//   (PIN, opcode, amount) into the cycle-level card/password/opcode sequence
//   seen by the ATM core. It watches the ATM status flags and returns a
//   one-cycle response carrying status and balance. After a request with
//   req_more=1 the card stays inserted, so the next operation skips the
//   insert/authenticate phases.
//
// Parameters
//   TIMEOUT_CYCLES  cycles waited in AUTH, OPER, HOLD or EJECT before giving up
//   BAL_W           width of Current_Balance / rsp_balance
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready       host request handshake
//   req_password, req_opcode,
//   req_amount, req_language,
//   req_more                    request fields, registered at accept
//   rsp_valid, rsp_status,
//   rsp_balance                 one-cycle response (status: 0 OK, 1 BAD_PIN,
//                               2 TIMEOUT, 3 BAD_OPCODE)
//   cardIn, Language, password,
//   opCode, inputAmount,
//   moneyDeposited, ejectCard,
//   Another_Operation           outputs driven to the ATM core
//   correctPassword, Input_Approved, Balance_Shown, Deposited_Successfully,
//   Withdrawed_Successfully, ATM_Usage_Finished, Current_Balance
//                               status inputs from the ATM core
// -----------------------------------------------------------------------------
module atm_session_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int BAL_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_password,
  input  logic [1:0]       req_opcode,
  input  logic [6:0]       req_amount,
  input  logic             req_language,
  input  logic             req_more,
  output logic             rsp_valid,
  output logic [1:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             cardIn,
  output logic             Language,
  output logic             moneyDeposited,
  output logic             ejectCard,
  output logic             Another_Operation,
  output logic [3:0]       password,
  output logic [1:0]       opCode,
  output logic [6:0]       inputAmount,
  input  logic             correctPassword,
  input  logic             Input_Approved,
  input  logic             Balance_Shown,
  input  logic             Deposited_Successfully,
  input  logic             Withdrawed_Successfully,
  input  logic             ATM_Usage_Finished,
  input  logic [BAL_W-1:0] Current_Balance
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INSERT = 3'd1;
  localparam logic [2:0] S_AUTH   = 3'd2;
  localparam logic [2:0] S_OPER   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [2:0] S_EJECT  = 3'd6;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_PIN = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BAD_OP  = 2'd3;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pw;
  logic             r_lang;
  logic [1:0]       r_op;
  logic [6:0]       r_amt;
  logic             r_more;
  logic             r_another;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_status;
  logic [BAL_W-1:0] r_rsp_balance;

  logic       w_ready;
  logic       w_accept;
  logic       w_legal;
  logic       w_timeout;
  logic       w_done_flag;
  logic       w_timed;
  logic [2:0] w_next;
  logic       w_ok;
  logic       w_fail;
  logic [1:0] w_fail_status;
  logic       w_bad_op;
  logic       w_cnt_clr;

  // Input_Approved is deliberately ignored: completion is judged only by the
  // per-opcode success flag.
  logic w_unused;
  assign w_unused = Input_Approved;

  // Readiness is masked during reset so the handshake output also reads 0.
  assign w_ready   = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign req_ready = w_ready && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_legal   = (req_opcode != OP_ILL);
  assign w_timeout = (r_cnt == CNT_LAST);
  assign w_timed   = (r_state == S_AUTH) || (r_state == S_OPER) ||
                     (r_state == S_HOLD) || (r_state == S_EJECT);

  always_comb begin
    w_done_flag = 1'b0;
    case (r_op)
      OP_BAL:  w_done_flag = Balance_Shown;
      OP_WD:   w_done_flag = Withdrawed_Successfully;
      OP_DEP:  w_done_flag = Deposited_Successfully;
      default: w_done_flag = 1'b0;
    endcase
  end

  // Next state and response events. In every waiting state the event test
  // comes before the timeout test, so a coincident event wins.
  always_comb begin
    w_next        = r_state;
    w_ok          = 1'b0;
    w_fail        = 1'b0;
    w_fail_status = ST_BAD_PIN;
    w_bad_op      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_legal) w_next = S_INSERT;
          else         w_bad_op = 1'b1;
        end
      end
      S_INSERT: w_next = S_AUTH;
      S_AUTH: begin
        if (correctPassword) begin
          w_next = S_OPER;
        end else if (w_timeout) begin
          w_next        = S_EJECT;
          w_fail        = 1'b1;
          w_fail_status = ST_BAD_PIN;
        end
      end
      S_OPER: begin
        if (w_done_flag) begin
          w_next = S_RESP;
          w_ok   = 1'b1;
        end else if (w_timeout) begin
          w_next        = S_EJECT;
          w_fail        = 1'b1;
          w_fail_status = ST_TIMEOUT;
        end
      end
      S_RESP: w_next = r_more ? S_HOLD : S_EJECT;
      S_HOLD: begin
        if (w_accept) begin
          if (w_legal) w_next = S_OPER;
          else         w_bad_op = 1'b1;
        end else if (w_timeout) begin
          w_next = S_EJECT;
        end
      end
      S_EJECT: begin
        if (ATM_Usage_Finished || w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // An illegal request in HOLD keeps the state but restarts the hold timer.
  assign w_cnt_clr = (w_next != r_state) || w_bad_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pw          <= '0;
      r_lang        <= 1'b0;
      r_op          <= '0;
      r_amt         <= '0;
      r_more        <= 1'b0;
      r_another     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_balance <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_cnt_clr || !w_timed) ? '0 : r_cnt + 1'b1;
      r_another   <= (r_state == S_HOLD) && w_accept && w_legal;
      r_rsp_valid <= w_ok || w_fail || w_bad_op;

      if (w_ok) begin
        r_rsp_status  <= ST_OK;
        r_rsp_balance <= Current_Balance;
      end else if (w_fail) begin
        r_rsp_status  <= w_fail_status;
        r_rsp_balance <= '0;
      end else if (w_bad_op) begin
        r_rsp_status  <= ST_BAD_OP;
        r_rsp_balance <= '0;
      end

      // Illegal requests leave every ATM-facing field untouched. The PIN and
      // language are only taken at a fresh insert; chained ops reuse them.
      if (w_accept && w_legal) begin
        r_op   <= req_opcode;
        r_amt  <= req_amount;
        r_more <= req_more;
        if (r_state == S_IDLE) begin
          r_pw   <= req_password;
          r_lang <= req_language;
        end
      end
    end
  end

  assign cardIn            = (r_state == S_INSERT) || (r_state == S_AUTH) ||
                             (r_state == S_OPER)   || (r_state == S_RESP) ||
                             (r_state == S_HOLD);
  assign password          = cardIn ? r_pw : 4'd0;
  assign Language          = cardIn && r_lang;
  assign opCode            = (r_state == S_OPER) ? r_op  : 2'd0;
  assign inputAmount       = (r_state == S_OPER) ? r_amt : 7'd0;
  assign moneyDeposited    = (r_state == S_OPER) && (r_op == OP_DEP);
  assign ejectCard         = (r_state == S_EJECT);
  assign Another_Operation = r_another;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_status        = r_rsp_status;
  assign rsp_balance       = r_rsp_balance;

endmodule

// File: tb/tb_atm_session_driver.sv
// -----------------------------------------------------------------------------
// tb_atm_session_driver
//   Self-checking bench for atm_session_driver. The bench plays both the host
//   and the ATM core. Per transaction, the ATM raises correctPassword and the
//   completion flag at chosen cycle offsets after the accept. Expected
//   response cycle, status and balance come from table constants or from a
//   transaction-level latency model.
// -----------------------------------------------------------------------------
module tb_atm_session_driver;

  localparam int BAL_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_password;
  logic [1:0]       req_opcode;
  logic [6:0]       req_amount;
  logic             req_language;
  logic             req_more;
  logic             rsp_valid;
  logic [1:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;
  logic             cardIn, Language, moneyDeposited, ejectCard, Another_Operation;
  logic [3:0]       password;
  logic [1:0]       opCode;
  logic [6:0]       inputAmount;
  logic             correctPassword, Input_Approved, Balance_Shown;
  logic             Deposited_Successfully, Withdrawed_Successfully, ATM_Usage_Finished;
  logic [BAL_W-1:0] Current_Balance;

  int n_checks = 0;
  int n_errors = 0;

  atm_session_driver #(.TIMEOUT_CYCLES(64), .BAL_W(BAL_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_password(req_password), .req_opcode(req_opcode), .req_amount(req_amount),
    .req_language(req_language), .req_more(req_more),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
    .cardIn(cardIn), .Language(Language), .moneyDeposited(moneyDeposited),
    .ejectCard(ejectCard), .Another_Operation(Another_Operation),
    .password(password), .opCode(opCode), .inputAmount(inputAmount),
    .correctPassword(correctPassword), .Input_Approved(Input_Approved),
    .Balance_Shown(Balance_Shown), .Deposited_Successfully(Deposited_Successfully),
    .Withdrawed_Successfully(Withdrawed_Successfully),
    .ATM_Usage_Finished(ATM_Usage_Finished), .Current_Balance(Current_Balance)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pw;
    logic [1:0]  op;
    logic [6:0]  amt;
    logic        lang;
    int          a;        // correctPassword raised from cycle 2+a after accept
    int          b;        // completion flag raised b cycles into OPER
    logic [31:0] bal;
    int          exp_lat;
    logic [1:0]  exp_st;
    logic [31:0] exp_bal;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint all_outputs();
    return 64'({req_ready, rsp_valid, rsp_status, rsp_balance, cardIn, Language,
                moneyDeposited, ejectCard, Another_Operation, password, opCode,
                inputAmount});
  endfunction

  task automatic clear_atm();
    correctPassword         = 1'b0;
    Input_Approved          = 1'b0;
    Balance_Shown           = 1'b0;
    Deposited_Successfully  = 1'b0;
    Withdrawed_Successfully = 1'b0;
  endtask

  // Transaction-level model: response cycle (accept cycle = 0) and status.
  function automatic void predict(input bit hold, input logic [1:0] op,
                                  input int a, input int b,
                                  output int lat, output logic [1:0] st);
    int start;
    if (op == 2'd3) begin
      lat = 1; st = 2'd3;
    end else if (!hold && a > 63) begin
      lat = 66; st = 2'd1;
    end else begin
      start = hold ? 1 : 3 + a;
      if (b > 63) begin lat = start + 64; st = 2'd2; end
      else        begin lat = start + b + 1; st = 2'd0; end
    end
  endfunction

  // Issues one request and plays the ATM until the response arrives.
  // Called and returns at a negedge; on return the response cycle is current.
  task automatic run_txn(input string tag, input bit hold, input logic [3:0] pw,
                         input logic [1:0] op, input logic [6:0] amt,
                         input bit lang, input bit more, input int a, input int b,
                         input logic [31:0] bal, input bit distract,
                         input int exp_lat, input logic [1:0] exp_st,
                         input logic [31:0] exp_bal);
    int t, lat, money, another, rises, waited, oper_start, money_exp;
    bit prev_card, reached, fon, ej;
    logic [1:0]  st;
    logic [31:0] rb;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({tag, "_ready_wait"}, 0, 1);
      return;
    end
    reached    = (op != 2'd3) && (hold || a < 64);
    oper_start = hold ? 1 : 3 + a;
    prev_card  = cardIn;
    req_valid = 1'b1; req_password = pw; req_opcode = op; req_amount = amt;
    req_language = lang; req_more = more; Current_Balance = bal;
    lat = -1; money = 0; another = 0; rises = 0; st = 2'd0; rb = '0; ej = 1'b0;
    t = 0;
    while (lat < 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (t == 1) req_valid = 1'b0;
      if (cardIn && !prev_card) rises++;
      prev_card = cardIn;
      if (moneyDeposited) money++;
      if (Another_Operation) another++;
      if (!hold && op != 2'd3 && t == 1) begin
        check({tag, "_insert_pw"}, password, pw);
        check({tag, "_insert_lang"}, Language, lang);
      end
      if (reached && t == oper_start) begin
        check({tag, "_oper_op"}, opCode, op);
        check({tag, "_oper_amt"}, inputAmount, amt);
      end
      if (rsp_valid) begin
        lat = t; st = rsp_status; rb = rsp_balance; ej = ejectCard;
        clear_atm();
      end else begin
        fon = reached && (t >= oper_start + b);
        correctPassword         = !hold && (t >= 2 + a);
        Balance_Shown           = (fon && op == 2'd0) || (distract && op == 2'd2);
        Withdrawed_Successfully = (fon && op == 2'd1) || (distract && op == 2'd0);
        Deposited_Successfully  = (fon && op == 2'd2) || (distract && op == 2'd1);
        Input_Approved          = 1'($urandom_range(0, 1));
      end
    end
    money_exp = (reached && op == 2'd2) ? ((b < 64) ? b + 1 : 64) : 0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_status"}, st, exp_st);
    check({tag, "_balance"}, rb, exp_bal);
    check({tag, "_money_cycles"}, money, money_exp);
    check({tag, "_another_pulses"}, another, (hold && op != 2'd3) ? 1 : 0);
    check({tag, "_card_rises"}, rises, (!hold && op != 2'd3) ? 1 : 0);
    check({tag, "_eject_at_rsp"}, ej, (exp_st == 2'd1 || exp_st == 2'd2) ? 1 : 0);
  endtask

  // Finishes a session: acknowledges ejectCard after e cycles, expects IDLE.
  task automatic do_eject(input string tag, input int e);
    int k, n, stray;
    bit seen, done;
    k = 0; n = 0; stray = 0; seen = 1'b0; done = 1'b0;
    ATM_Usage_Finished = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) stray++;
      if (ejectCard) begin
        seen = 1'b1;
        if (cardIn) stray++;
        if (k >= e) ATM_Usage_Finished = 1'b1;
        k++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    ATM_Usage_Finished = 1'b0;
    check({tag, "_eject_done"}, done, 1);
    check({tag, "_eject_clean"}, stray, 0);
    check({tag, "_idle_state"}, {req_ready, cardIn, ejectCard}, 3'b100);
  endtask

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt, stray, lat, a, b;
    logic [1:0] op, st;
    bit   hold, more;
    logic [31:0] bal;

    reset = 1'b1; req_valid = 1'b0; req_password = '0; req_opcode = '0;
    req_amount = '0; req_language = 1'b0; req_more = 1'b0;
    clear_atm(); ATM_Usage_Finished = 1'b0; Current_Balance = '0;

    vecs[0] = '{4'b1010, 2'd0, 7'd0,  1'b0, 1,   0,  32'd500, 5,  2'd0, 32'd500};
    vecs[1] = '{4'd5,    2'd1, 7'd5,  1'b1, 0,   0,  32'd123, 4,  2'd0, 32'd123};
    vecs[2] = '{4'd9,    2'd2, 7'd20, 1'b0, 2,   3,  32'd999, 9,  2'd0, 32'd999};
    vecs[3] = '{4'd1,    2'd3, 7'd7,  1'b1, 0,   0,  32'd42,  1,  2'd3, 32'd0};
    vecs[4] = '{4'd2,    2'd0, 7'd0,  1'b0, 200, 0,  32'd55,  66, 2'd1, 32'd0};
    vecs[5] = '{4'd3,    2'd0, 7'd0,  1'b1, 0,   70, 32'd66,  67, 2'd2, 32'd0};
    vecs[6] = '{4'd4,    2'd1, 7'd3,  1'b0, 63,  0,  32'd700, 67, 2'd0, 32'd700};
    vecs[7] = '{4'd6,    2'd2, 7'd1,  1'b1, 0,   63, 32'd77,  67, 2'd0, 32'd77};
    vecs[8] = '{4'd7,    2'd1, 7'd2,  1'b0, 0,   64, 32'd88,  67, 2'd2, 32'd0};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {req_ready, cardIn, ejectCard, rsp_valid}, 4'b1000);

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), 1'b0, vecs[i].pw, vecs[i].op, vecs[i].amt,
              vecs[i].lang, 1'b0, vecs[i].a, vecs[i].b, vecs[i].bal, 1'(i % 2),
              vecs[i].exp_lat, vecs[i].exp_st, vecs[i].exp_bal);
      if (vecs[i].op != 2'd3) do_eject($sformatf("vec%0d", i), 1);
    end

    // Deposit with card kept in, then a withdraw chained from HOLD.
    run_txn("chain_dep", 1'b0, 4'd11, 2'd2, 7'd20, 1'b1, 1'b1, 1, 2, 32'd520, 1'b0,
            7, 2'd0, 32'd520);
    run_txn("chain_wd", 1'b1, 4'd0, 2'd1, 7'd5, 1'b0, 1'b0, 0, 1, 32'd515, 1'b1,
            3, 2'd0, 32'd515);
    do_eject("chain", 2);

    // Reset in the middle of a deposit OPER.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_password = 4'd3; req_opcode = 2'd2; req_amount = 7'd9;
    req_language = 1'b1; req_more = 1'b0; Current_Balance = 32'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    correctPassword = 1'b1;
    @(negedge clk);
    check("oper_money_before_reset", {cardIn, moneyDeposited}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_oper_outputs", all_outputs(), 0);
    reset = 1'b0;
    clear_atm();
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || ejectCard || cardIn) stray++;
    end
    check("post_reset_quiet", stray, 0);
    check("post_reset_ready", req_ready, 1);

    // HOLD timeout; an illegal request mid-HOLD must restart the hold timer.
    run_txn("hold_pre", 1'b0, 4'd8, 2'd0, 7'd0, 1'b0, 1'b1, 0, 0, 32'd300, 1'b0,
            4, 2'd0, 32'd300);
    stray = 0;
    repeat (31) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    run_txn("hold_ill", 1'b1, 4'd0, 2'd3, 7'd0, 1'b0, 1'b0, 0, 0, 32'd9, 1'b0,
            1, 2'd3, 32'd0);
    cnt = (cardIn && !ejectCard) ? 1 : 0;
    while (!ejectCard && cnt < 100) begin
      @(negedge clk);
      if (rsp_valid) stray++;
      if (cardIn && !ejectCard) cnt++;
    end
    check("hold_cycles_after_restart", cnt, 64);
    check("hold_timeout_no_rsp", stray, 0);
    do_eject("hold", 0);

    // Randomised sessions against the latency model.
    for (int s = 0; s < 30; s++) begin
      hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
        op = (k < 3 && $urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = ($urandom_range(0, 11) == 0) ? 64 + $urandom_range(0, 3) : $urandom_range(0, 3);
        b  = ($urandom_range(0, 11) == 0) ? 62 + $urandom_range(0, 5) : $urandom_range(0, 3);
        more = (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        bal  = $urandom;
        predict(hold, op, a, b, lat, st);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_txn($sformatf("rnd%0d_%0d", s, k), hold, 4'($urandom), op, 7'($urandom),
                1'($urandom), more, a, b, bal, 1'($urandom_range(0, 1)),
                lat, st, (st == 2'd0) ? bal : 32'd0);
        if (op == 2'd3) continue;
        if (st == 2'd0 && more) begin
          hold = 1'b1;
        end else begin
          do_eject($sformatf("rnd%0d", s), $urandom_range(0, 2));
          break;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
